// File: rtl/rx_frame_sequencer_if.sv
// rx_frame_sequencer_if: bit-in / octet-out bundle for the receive frame sequencer.
//   rx_en, bit_in, bit_valid, byte_ready        : driven by the demod/host/MAC side
//   byte_data, byte_valid, byte_last, frame_len,
//   frame_start, frame_done, frame_err,
//   err_code, fcs_ok, busy                      : driven by the sequencer
interface rx_frame_sequencer_if;
    logic       rx_en;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;
    logic [6:0] frame_len;
    logic       frame_start;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       fcs_ok;
    logic       busy;

    // Environment side (demodulator, host, MAC)
    modport master (
        output rx_en, bit_in, bit_valid, byte_ready,
        input  byte_data, byte_valid, byte_last, frame_len,
               frame_start, frame_done, frame_err, err_code, fcs_ok, busy
    );

    // Sequencer side
    modport slave (
        input  rx_en, bit_in, bit_valid, byte_ready,
        output byte_data, byte_valid, byte_last, frame_len,
               frame_start, frame_done, frame_err, err_code, fcs_ok, busy
    );
endinterface

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: hunts for the SFD, captures/validates the PHR length,
// delimits the PSDU (FCS included) and packs it LSB-first into octets.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rx_frame_sequencer_if.slave (bit input, octet valid/ready output,
//              frame_start/done/err pulses, err_code, frame_len, fcs_ok, busy)
// Optional build macro RX_FCS_CHECK_EN: adds a CRC-16 (x^16+x^12+x^5+1,
// LSB-first, init 0) over the PSDU; fcs_ok reports a zero remainder.
// Without it fcs_ok is simply 1 with frame_done.
module rx_frame_sequencer #(
    parameter int unsigned            SYNC_LEN     = 16,
    parameter logic [SYNC_LEN-1:0]    SYNC_WORD    = 16'hF398,
    parameter int unsigned            MIN_LEN      = 5,
    parameter int unsigned            MAX_LEN      = 127,
    parameter int unsigned            TIMEOUT_BITS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_frame_sequencer_if.slave  bus
);

    localparam int unsigned HCW = $clog2(TIMEOUT_BITS + 1);
    localparam int unsigned CW  = 10;

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_PHR, S_PSDU} state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] sh_q, sh_d;
    logic [HCW-1:0]      hunt_q, hunt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          asm_q, asm_d;
    logic [7:0]          byte_data_q, byte_data_d;
    logic                byte_valid_q, byte_valid_d;
    logic                byte_last_q, byte_last_d;
    logic [6:0]          frame_len_q, frame_len_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                fcs_ok_q, fcs_ok_d;
    logic                busy_q, busy_d;

    // Shared per-bit conditions
    logic [SYNC_LEN-1:0] sh_shift;
    logic                sync_hit;
    logic                hunt_to;
    logic [7:0]          asm_shift;
    logic [6:0]          phr_len;
    logic                len_bad;
    logic                phr_end;
    logic [CW-1:0]       cnt_dec;
    logic                oct_done;
    logic                psdu_end;
    logic                ovf;
    logic                fcs_pass;

    assign sh_shift  = {sh_q[SYNC_LEN-2:0], bus.bit_in};
    assign sync_hit  = (sh_shift == SYNC_WORD);
    assign hunt_to   = (hunt_q == HCW'(TIMEOUT_BITS - 1));
    assign asm_shift = {bus.bit_in, asm_q[7:1]};
    assign phr_len   = asm_shift[6:0];
    assign len_bad   = (32'(phr_len) < MIN_LEN) || (32'(phr_len) > MAX_LEN);
    assign phr_end   = (cnt_q == CW'(7));
    assign cnt_dec   = cnt_q - CW'(1);
    assign oct_done  = (cnt_dec[2:0] == 3'd0);
    assign psdu_end  = (cnt_dec == CW'(0));
    assign ovf       = byte_valid_q && !bus.byte_ready;

`ifdef RX_FCS_CHECK_EN
    logic [15:0] crc_q, crc_d, crc_next;
    logic        crc_fb;

    // Reflected CRC-16/CCITT step; remainder over data+FCS is zero when intact
    assign crc_fb   = crc_q[0] ^ bus.bit_in;
    assign crc_next = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'h8408 : 16'h0000);
    assign fcs_pass = (crc_next == 16'h0000);

    always_comb begin
        crc_d = crc_q;
        if (bus.rx_en && bus.bit_valid) begin
            if (state_q == S_HUNT && sync_hit) begin
                crc_d = 16'h0000;
            end else if (state_q == S_PSDU) begin
                crc_d = crc_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign fcs_pass = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!bus.rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_HUNT;
                S_HUNT: if (bus.bit_valid && sync_hit) state_d = S_PHR;
                S_PHR:  if (bus.bit_valid && phr_end) state_d = len_bad ? S_HUNT : S_PSDU;
                S_PSDU: if (bus.bit_valid && oct_done && (ovf || psdu_end)) state_d = S_HUNT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        sh_d         = sh_q;
        hunt_d       = hunt_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q && !bus.byte_ready;
        byte_last_d  = byte_last_q;
        frame_len_d  = frame_len_q;
        start_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        fcs_ok_d     = 1'b0;
        busy_d       = (state_d == S_PHR) || (state_d == S_PSDU);

        if (!bus.rx_en) begin
            // Abort: drop any held octet silently, keep length and error code
            byte_valid_d = 1'b0;
            sh_d         = '0;
            hunt_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sh_d   = '0;
                    hunt_d = '0;
                end
                S_HUNT: if (bus.bit_valid) begin
                    sh_d   = sh_shift;
                    hunt_d = hunt_q + HCW'(1);
                    // A match on the timeout bit wins over the timeout
                    if (sync_hit) begin
                        start_d    = 1'b1;
                        sh_d       = '0;
                        hunt_d     = '0;
                        cnt_d      = '0;
                        err_code_d = 2'b00;
                    end else if (hunt_to) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        sh_d       = '0;
                        hunt_d     = '0;
                    end
                end
                S_PHR: if (bus.bit_valid) begin
                    asm_d = asm_shift;
                    cnt_d = cnt_q + CW'(1);
                    if (phr_end) begin
                        frame_len_d = phr_len;
                        if (len_bad) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b10;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = {phr_len, 3'b000};
                        end
                    end
                end
                S_PSDU: if (bus.bit_valid) begin
                    asm_d = asm_shift;
                    cnt_d = cnt_dec;
                    if (oct_done) begin
                        if (ovf) begin
                            // Held octet stays presented; the new one is lost
                            err_d      = 1'b1;
                            err_code_d = 2'b11;
                            cnt_d      = '0;
                        end else begin
                            byte_data_d  = asm_shift;
                            byte_valid_d = 1'b1;
                            byte_last_d  = psdu_end;
                            if (psdu_end) begin
                                done_d   = 1'b1;
                                fcs_ok_d = fcs_pass;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q         <= '0;
            hunt_q       <= '0;
            cnt_q        <= '0;
            asm_q        <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            frame_len_q  <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            fcs_ok_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            hunt_q       <= hunt_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            frame_len_q  <= frame_len_d;
            start_q      <= start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            fcs_ok_q     <= fcs_ok_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.byte_data   = byte_data_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.byte_last   = byte_last_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.err_code    = err_code_q;
    assign bus.fcs_ok      = fcs_ok_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer: scenario tasks drive bit streams; expected octets are
// queued as they are transmitted and compared when the DUT hands them over.
module tb_rx_frame_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_frame_sequencer_if ifc ();

    rx_frame_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [7:0]  pay[$];
    logic [15:0] sync_w = 16'hF398;

    int checks = 0;
    int fails  = 0;
    int gap    = 0;
    int n_start = 0, n_done = 0, n_err = 0, n_bytes = 0;
    int s_start, s_done, s_err, s_bytes;
    logic       last_fcs = 1'b0;

    // Event counters and octet scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.frame_start) n_start++;
            if (ifc.frame_err) n_err++;
            if (ifc.frame_done) begin
                n_done++;
                last_fcs = ifc.fcs_ok;
            end
            if (ifc.byte_valid && ifc.byte_ready) begin
                n_bytes++;
                checks++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL byte_unexpected: got %02h last=%0b, required no octet", ifc.byte_data, ifc.byte_last);
                end else begin
                    e = sbq.pop_front();
                    if ({ifc.byte_data, ifc.byte_last} !== {e.data, e.last}) begin
                        fails++;
                        $display("FAIL byte_data: got %02h last=%0b, required %02h last=%0b",
                                 ifc.byte_data, ifc.byte_last, e.data, e.last);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = {1'b0, r[15:1]} ^ 16'h8408;
            else             r = {1'b0, r[15:1]};
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        s_start = n_start; s_done = n_done; s_err = n_err; s_bytes = n_bytes;
    endtask

    task automatic send_bit(input logic b);
        ifc.bit_in    = b;
        ifc.bit_valid = 1'b1;
        @(posedge clk); #1;
        ifc.bit_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input bit last);
        exp_t x;
        if (push) begin
            x.data = b; x.last = last;
            sbq.push_back(x);
        end
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_preamble_sync();
        for (int i = 0; i < 64; i++) send_bit(i[0]);
        for (int i = 15; i >= 0; i--) send_bit(sync_w[i]);
    endtask

    task automatic add_fcs();
        logic [15:0] c;
        c = 16'h0000;
        foreach (pay[i]) c = crc_byte(c, pay[i]);
        pay.push_back(c[7:0]);
        pay.push_back(c[15:8]);
    endtask

    task automatic build_fixed();
        pay.delete();
        pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h03);
        add_fcs();
    endtask

    task automatic send_frame(input logic [7:0] phr);
        send_preamble_sync();
        send_byte(phr, 1'b0, 1'b0);
        foreach (pay[i]) send_byte(pay[i], 1'b1, i == pay.size() - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.rx_en = 1'b0; ifc.bit_in = 1'b0; ifc.bit_valid = 1'b0; ifc.byte_ready = 1'b1;
        idle(3);
        checks++;
        if ({ifc.byte_data, ifc.byte_valid, ifc.byte_last, ifc.frame_len, ifc.frame_start,
             ifc.frame_done, ifc.frame_err, ifc.err_code, ifc.fcs_ok, ifc.busy} !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs: got data=%02h v=%0b len=%0d err=%0d busy=%0b, required all 0",
                     ifc.byte_data, ifc.byte_valid, ifc.frame_len, ifc.err_code, ifc.busy);
        end
        rst = 1'b0;
        ifc.rx_en = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame();
        build_fixed();
        snap();
        send_frame(8'h05);
        idle(4);
        checks++;
        if ({n_start - s_start, n_done - s_done, n_err - s_err} !== {32'd1, 32'd1, 32'd0}) begin
            fails++;
            $display("FAIL good_pulses: got start=%0d done=%0d err=%0d, required 1 1 0",
                     n_start - s_start, n_done - s_done, n_err - s_err);
        end
        checks++;
        if (last_fcs !== 1'b1) begin
            fails++; $display("FAIL good_fcs: got %0b, required 1", last_fcs);
        end
        checks++;
        if (ifc.frame_len !== 7'd5) begin
            fails++; $display("FAIL good_len: got %0d, required 5", ifc.frame_len);
        end
        checks++;
        if ((n_bytes - s_bytes) !== 5 || sbq.size() !== 0) begin
            fails++; $display("FAIL good_bytes: got %0d left=%0d, required 5 left=0", n_bytes - s_bytes, sbq.size());
        end
        checks++;
        if (ifc.busy !== 1'b0) begin
            fails++; $display("FAIL good_busy: got %0b, required 0", ifc.busy);
        end
    endtask

`ifdef RX_FCS_CHECK_EN
    task automatic test_fcs_bad();
        build_fixed();
        pay[1] = pay[1] ^ 8'h04;
        snap();
        send_frame(8'h05);
        idle(4);
        checks++;
        if ({n_done - s_done, n_err - s_err, 31'd0, last_fcs} !== {32'd1, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL fcs_bad: got done=%0d err=%0d fcs=%0b, required 1 0 0", n_done - s_done, n_err - s_err, last_fcs);
        end
    endtask
`endif

    task automatic test_timeout();
        snap();
        for (int i = 0; i < 1023; i++) send_bit(~i[0]);
        idle(2);
        checks++;
        if ((n_err - s_err) !== 0) begin
            fails++; $display("FAIL timeout_early: got %0d errs, required 0", n_err - s_err);
        end
        send_bit(1'b0);
        idle(2);
        checks++;
        if ((n_err - s_err) !== 1 || ifc.err_code !== 2'b01 || ifc.busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err: got errs=%0d code=%0d busy=%0b, required 1 1 0", n_err - s_err, ifc.err_code, ifc.busy);
        end
        // Sync landing exactly on the 1024th bit of the new window
        snap();
        for (int i = 0; i < 1008; i++) send_bit(~i[0]);
        for (int i = 15; i >= 0; i--) send_bit(sync_w[i]);
        idle(2);
        checks++;
        if ((n_start - s_start) !== 1 || (n_err - s_err) !== 0 || ifc.err_code !== 2'b00) begin
            fails++;
            $display("FAIL timeout_sync: got start=%0d err=%0d code=%0d, required 1 0 0",
                     n_start - s_start, n_err - s_err, ifc.err_code);
        end
        build_fixed();
        send_byte(8'h05, 1'b0, 1'b0);
        foreach (pay[i]) send_byte(pay[i], 1'b1, i == pay.size() - 1);
        idle(4);
        checks++;
        if ((n_done - s_done) !== 1 || sbq.size() !== 0) begin
            fails++; $display("FAIL timeout_frame: got done=%0d left=%0d, required 1 0", n_done - s_done, sbq.size());
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] phrs [2];
        phrs[0] = 8'h04; phrs[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            snap();
            send_preamble_sync();
            send_byte(phrs[k], 1'b0, 1'b0);
            idle(3);
            checks++;
            if ((n_err - s_err) !== 1 || ifc.err_code !== 2'b10 || (n_bytes - s_bytes) !== 0
                || ifc.byte_valid !== 1'b0 || ifc.frame_len !== phrs[k][6:0]) begin
                fails++;
                $display("FAIL bad_len_%02h: got err=%0d code=%0d bytes=%0d len=%0d, required 1 2 0 %0d",
                         phrs[k], n_err - s_err, ifc.err_code, n_bytes - s_bytes, ifc.frame_len, phrs[k][6:0]);
            end
        end
        pay.delete();
        for (int i = 0; i < 125; i++) pay.push_back(8'($urandom_range(0, 255)));
        add_fcs();
        snap();
        send_frame(8'hFF);
        idle(4);
        checks++;
        if ((n_bytes - s_bytes) !== 127 || (n_done - s_done) !== 1 || ifc.frame_len !== 7'd127
            || last_fcs !== 1'b1 || sbq.size() !== 0) begin
            fails++;
            $display("FAIL max_len: got bytes=%0d done=%0d len=%0d fcs=%0b, required 127 1 127 1",
                     n_bytes - s_bytes, n_done - s_done, ifc.frame_len, last_fcs);
        end
    endtask

    task automatic test_overflow();
        build_fixed();
        ifc.byte_ready = 1'b0;
        snap();
        send_preamble_sync();
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(pay[0], 1'b1, 1'b0);
        send_byte(pay[1], 1'b0, 1'b0);
        idle(2);
        checks++;
        if ((n_err - s_err) !== 1 || ifc.err_code !== 2'b11 || (n_done - s_done) !== 0 || ifc.busy !== 1'b0) begin
            fails++;
            $display("FAIL ovf_err: got err=%0d code=%0d done=%0d busy=%0b, required 1 3 0 0",
                     n_err - s_err, ifc.err_code, n_done - s_done, ifc.busy);
        end
        checks++;
        if (ifc.byte_valid !== 1'b1 || ifc.byte_data !== pay[0]) begin
            fails++;
            $display("FAIL ovf_hold: got v=%0b data=%02h, required 1 %02h", ifc.byte_valid, ifc.byte_data, pay[0]);
        end
        ifc.byte_ready = 1'b1;
        idle(2);
        checks++;
        if ((n_bytes - s_bytes) !== 1 || sbq.size() !== 0 || ifc.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovf_drain: got bytes=%0d left=%0d v=%0b, required 1 0 0", n_bytes - s_bytes, sbq.size(), ifc.byte_valid);
        end
    endtask

    task automatic test_rx_en_drop();
        build_fixed();
        snap();
        send_preamble_sync();
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(pay[0], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(pay[1][i]);
        ifc.rx_en = 1'b0;
        idle(1);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.byte_valid !== 1'b0) begin
            fails++; $display("FAIL drop_idle: got busy=%0b v=%0b, required 0 0", ifc.busy, ifc.byte_valid);
        end
        idle(3);
        checks++;
        if ((n_done - s_done) !== 0 || (n_err - s_err) !== 0 || ifc.frame_len !== 7'd5) begin
            fails++;
            $display("FAIL drop_pulses: got done=%0d err=%0d len=%0d, required 0 0 5", n_done - s_done, n_err - s_err, ifc.frame_len);
        end
        ifc.rx_en = 1'b1;
        idle(2);
        snap();
        send_frame(8'h05);
        idle(4);
        checks++;
        if ((n_done - s_done) !== 1 || (n_bytes - s_bytes) !== 5 || sbq.size() !== 0) begin
            fails++;
            $display("FAIL drop_reenable: got done=%0d bytes=%0d left=%0d, required 1 5 0", n_done - s_done, n_bytes - s_bytes, sbq.size());
        end
    endtask

    task automatic test_gap_reset();
        logic [7:0] phr;
        phr = 8'h05;
        gap = 2;
        build_fixed();
        send_preamble_sync();
        for (int i = 0; i < 4; i++) send_bit(phr[i]);
        rst = 1'b1;
        #2;
        checks++;
        if ({ifc.byte_data, ifc.byte_valid, ifc.byte_last, ifc.frame_len, ifc.frame_start,
             ifc.frame_done, ifc.frame_err, ifc.err_code, ifc.fcs_ok, ifc.busy} !== 24'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got len=%0d busy=%0b data=%02h, required all 0", ifc.frame_len, ifc.busy, ifc.byte_data);
        end
        idle(2);
        rst = 1'b0;
        idle(2);
        snap();
        send_frame(8'h05);
        idle(8);
        checks++;
        if ((n_start - s_start) !== 1 || (n_done - s_done) !== 1 || (n_bytes - s_bytes) !== 5
            || sbq.size() !== 0 || last_fcs !== 1'b1) begin
            fails++;
            $display("FAIL gap_frame: got start=%0d done=%0d bytes=%0d fcs=%0b, required 1 1 5 1",
                     n_start - s_start, n_done - s_done, n_bytes - s_bytes, last_fcs);
        end
        gap = 0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef RX_FCS_CHECK_EN
        test_fcs_bad();
`endif
        test_timeout();
        test_bad_len();
        test_overflow();
        test_rx_en_drop();
        test_gap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
